axi_rd_arbiter: RTL



---
 rtl/axi_pkg.sv | 35 +++
 rtl/axi_rr_arb.sv | 57 +++++
 rtl/axi_rd_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : axi_pkg                                               |
// | Purpose  : Shared AXI read-channel types and constants for the   |
// |            DMA read arbitration path.                            |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package axi_pkg;

    localparam int ID_BUS_WIDTH                 = 7;
    localparam int ADDR_WIDTH                   = 32;
    localparam int DATA_WIDTH                   = 32;
    localparam int MAX_OUTSTANDING_TRANSACTIONS = 8;
    localparam int NUM_RD_REQ                   = 4;

    // Wide enough to hold 0..MAX_OUTSTANDING_TRANSACTIONS inclusive
    typedef logic [$clog2(MAX_OUTSTANDING_TRANSACTIONS+1)-1:0] axi_rd_cnt_t;

    typedef struct packed {
        logic [ID_BUS_WIDTH-1:0] arid;
        logic [ADDR_WIDTH-1:0]   araddr;
        logic [7:0]              arlen;
        logic [2:0]              arsize;
        logic [1:0]              arburst;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [ID_BUS_WIDTH-1:0] rid;
        logic [DATA_WIDTH-1:0]   rdata;
        logic [1:0]              rresp;
        logic                    rlast;
    } axi_r_chan_t;

endpackage
`default_nettype wire

// File: rtl/axi_rr_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : axi_rr_arb                                            |
// | Purpose  : N-way round-robin priority select. Owns the rotating  |
// |            pointer, which moves one past the winner on a grant.  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module axi_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_adv,
    output logic [N-1:0]     o_gnt_oh,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    localparam logic [IDX_W:0] c_n = (IDX_W+1)'(N);

    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W:0]   w_sum;

    // Scan from the highest offset down so the lowest offset from the pointer wins
    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_sum     = '0;
        for (int k = N-1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= c_n) begin
                w_sum = w_sum - c_n;
            end
            if (i_req[w_sum[IDX_W-1:0]]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = w_sum[IDX_W-1:0];
            end
        end
        if (o_gnt_vld) begin
            o_gnt_oh[o_gnt_idx] = 1'b1;
        end
    end

    // Pointer advances to the requester after the winner, wrapping at N
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (i_adv && o_gnt_vld) begin
            r_rr_ptr <= (o_gnt_idx == IDX_W'(N-1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : axi_rd_arbiter                                        |
// | Purpose  : Shares one AXI read master (AR + R) between NUM_REQ   |
// |            DMA read requesters. Round-robin AR grant through a   |
// |            one-entry registered slot, requester index tagged in  |
// |            the upper ARID bits, R beats routed back by RID, and  |
// |            a per-requester cap on open bursts.                   |
// | Options  : AXI_RD_ARB_PERF_EN adds perf_grant_cnt_o, a 32-bit    |
// |            wrapping grant counter per requester.                 |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_REQ = NUM_RD_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ),
    parameter int MAX_OUT = MAX_OUTSTANDING_TRANSACTIONS
) (
    input  logic                clk,
    input  logic                rst,
    input  axi_ar_chan_t        req_ar_i      [NUM_REQ],
    input  logic [NUM_REQ-1:0]  req_arvalid_i,
    output logic [NUM_REQ-1:0]  req_arready_o,
    output axi_r_chan_t         req_r_o       [NUM_REQ],
    output logic [NUM_REQ-1:0]  req_rvalid_o,
    input  logic [NUM_REQ-1:0]  req_rready_i,
    output axi_ar_chan_t        m_ar_o,
    output logic                m_arvalid_o,
    input  logic                m_arready_i,
    input  axi_r_chan_t         m_r_i,
    input  logic                m_rvalid_i,
    output logic                m_rready_o,
    output logic                idle_o,
    output logic                err_o
`ifdef AXI_RD_ARB_PERF_EN
    ,
    output logic [31:0]         perf_grant_cnt_o [NUM_REQ]
`endif
);

    localparam int                 c_cnt_w   = $clog2(MAX_OUT+1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_OUT);
    localparam logic [IDX_W:0]     c_num_req = (IDX_W+1)'(NUM_REQ);

    logic [c_cnt_w-1:0] r_cnt [NUM_REQ];
    logic               r_slot_vld;
    axi_ar_chan_t       r_slot_ar;
    logic               r_err;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_cnt_zero;
    logic [NUM_REQ-1:0] w_r_sel;
    logic [NUM_REQ-1:0] w_dec;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_vld;
    logic               w_can_load;
    logic [IDX_W-1:0]   w_r_idx;
    logic               w_idx_ok;
    logic               w_r_last_hs;
    logic               w_uflow;
    axi_ar_chan_t       w_ar_tagged;
    axi_r_chan_t        w_r_clean;

    // Slot accepts a new AR when empty or when its current AR leaves this cycle;
    // held low during reset so no requester sees a handshake then
    assign w_can_load = !rst && (!r_slot_vld || m_arready_i);

    axi_rr_arb #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_elig & {NUM_REQ{w_can_load}}),
        .i_adv     (w_can_load),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    assign req_arready_o = w_gnt_oh;

    // Winner's AR with the requester index written over the top ID bits
    always_comb begin
        w_ar_tagged = req_ar_i[w_gnt_idx];
        w_ar_tagged.arid[ID_BUS_WIDTH-1 -: IDX_W] = w_gnt_idx;
    end

    // Registered AR slot: load on grant, otherwise drain on downstream ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_vld <= 1'b0;
            r_slot_ar  <= '0;
        end else if (w_gnt_vld) begin
            r_slot_vld <= 1'b1;
            r_slot_ar  <= w_ar_tagged;
        end else if (m_arready_i) begin
            r_slot_vld <= 1'b0;
        end
    end

    assign m_arvalid_o = r_slot_vld;
    assign m_ar_o      = r_slot_ar;

    // R routing: the index lives in the top RID bits
    assign w_r_idx = m_r_i.rid[ID_BUS_WIDTH-1 -: IDX_W];

    // Index values past NUM_REQ only exist when NUM_REQ is not a power of two
    if ((1 << IDX_W) > NUM_REQ) begin : g_idx_chk
        assign w_idx_ok = ({1'b0, w_r_idx} < c_num_req);
    end else begin : g_idx_full
        assign w_idx_ok = 1'b1;
    end

    // Requesters see their original RID with the index bits cleared
    always_comb begin
        w_r_clean = m_r_i;
        w_r_clean.rid[ID_BUS_WIDTH-1 -: IDX_W] = '0;
    end

    // Illegal index beats are sunk so they cannot stall the fabric
    assign m_rready_o  = !w_idx_ok || |(req_rready_i & w_r_sel);
    assign w_r_last_hs = m_rvalid_i && m_rready_o && m_r_i.rlast;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_elig[gi]       = req_arvalid_i[gi] && (r_cnt[gi] < c_cnt_max);
        assign w_cnt_zero[gi]   = (r_cnt[gi] == '0);
        assign w_r_sel[gi]      = w_idx_ok && (w_r_idx == IDX_W'(gi));
        assign req_rvalid_o[gi] = m_rvalid_i && w_r_sel[gi];
        assign req_r_o[gi]      = w_r_clean;
        assign w_dec[gi]        = w_r_last_hs && w_r_sel[gi];
    end

    assign w_uflow = |(w_dec & ~w_gnt_oh & w_cnt_zero);

    // Open-burst counters: +1 on grant, -1 on final beat, saturating at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt_oh[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !w_gnt_oh[i] && !w_cnt_zero[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Error pulse for a dropped illegal-index beat or a counter underflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (m_rvalid_i && !w_idx_ok) || w_uflow;
        end
    end

    assign err_o  = r_err;
    assign idle_o = !r_slot_vld && (&w_cnt_zero);

`ifdef AXI_RD_ARB_PERF_EN
    logic [31:0] r_perf [NUM_REQ];

    // Free-running grant counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_perf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt_oh[i]) begin
                    r_perf[i] <= r_perf[i] + 32'd1;
                end
            end
        end
    end

    assign perf_grant_cnt_o = r_perf;
`endif

endmodule
`default_nettype wire
